// File: rtl/qf_hw_evcnt_pkg.sv
// Shared types and default constants for the qf_hw_evcnt event counter.
package qf_hw_evcnt_pkg;

    localparam int unsigned DEF_BIT_WIDTH = 10;
    localparam int unsigned DEF_PERIOD    = 256;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/qf_hw_evcnt_if.sv
// Event/snapshot bus between the event source and the counter.
interface qf_hw_evcnt_if
    import qf_hw_evcnt_pkg::*;
#(
    parameter int unsigned PAR_BIT_WIDTH = DEF_BIT_WIDTH
);

    logic                     evt_i;
    logic                     cnt_en;
    logic                     snap_req;
    logic [PAR_BIT_WIDTH-1:0] hw_wrdata;
    logic                     hw_wr_en;
    logic                     ovf_o;

    modport master (
        output evt_i, cnt_en, snap_req,
        input  hw_wrdata, hw_wr_en, ovf_o
    );

    modport slave (
        input  evt_i, cnt_en, snap_req,
        output hw_wrdata, hw_wr_en, ovf_o
    );

endinterface

// File: rtl/qf_hw_evcnt_tmr.sv
// Period timer: counts RUN cycles 0..PAR_PERIOD-1 and flags the terminal cycle.
module qf_hw_evcnt_tmr
    import qf_hw_evcnt_pkg::*;
#(
    parameter int unsigned PAR_PERIOD = DEF_PERIOD
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    input  logic en,
    output logic term_c
);

    localparam int unsigned TMR_W = $clog2(PAR_PERIOD);

    logic [TMR_W-1:0] tmr;

    // Clear has priority so a push cycle restarts the window at 0.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmr <= '0;
        end else if (clr) begin
            tmr <= '0;
        end else if (en) begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    assign term_c = (tmr == TMR_W'(PAR_PERIOD - 1));

endmodule

// File: rtl/qf_hw_evcnt.sv
// Windowed event counter pushing saturated count snapshots to a HW-written register.
// Optional feature: define QF_HW_EVCNT_SNAP_REQ_EN to make snap_req a push cause.
module qf_hw_evcnt
    import qf_hw_evcnt_pkg::*;
#(
    parameter int unsigned PAR_BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int unsigned PAR_PERIOD    = DEF_PERIOD
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    qf_hw_evcnt_if.slave  bus
);

    localparam logic [PAR_BIT_WIDTH-1:0] CNT_MAX = '1;

    state_t                   state;
    logic [PAR_BIT_WIDTH-1:0] cnt;
    logic                     ovf;

    logic                     snap_c;
    logic                     inc_c;
    logic                     sat_c;
    logic                     push_c;
    logic [PAR_BIT_WIDTH-1:0] cnt_nxt_c;
    logic                     ovf_nxt_c;
    logic                     tmr_term_c;
    logic                     tmr_clr_c;
    logic                     tmr_en_c;

`ifdef QF_HW_EVCNT_SNAP_REQ_EN
    assign snap_c = bus.snap_req;
`else
    logic unused_snap;
    assign unused_snap = bus.snap_req;
    assign snap_c      = 1'b0;
`endif

    // Count/overflow including the current cycle's event, saturating at all-ones.
    assign inc_c     = bus.cnt_en & bus.evt_i;
    assign sat_c     = (cnt == CNT_MAX);
    assign cnt_nxt_c = cnt + PAR_BIT_WIDTH'(inc_c & ~sat_c);
    assign ovf_nxt_c = ovf | (inc_c & sat_c);

    // All push causes collapse into one push.
    assign push_c    = (state == RUN) & (tmr_term_c | snap_c | ~bus.cnt_en);

    assign tmr_clr_c = (state == IDLE) | push_c;
    assign tmr_en_c  = (state == RUN);

    qf_hw_evcnt_tmr #(
        .PAR_PERIOD (PAR_PERIOD)
    ) u_tmr (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (tmr_clr_c),
        .en      (tmr_en_c),
        .term_c  (tmr_term_c)
    );

    // Control FSM, accumulator and registered snapshot outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.hw_wr_en  <= 1'b0;
            bus.hw_wrdata <= '0;
            bus.ovf_o     <= 1'b0;
        end else begin
            bus.hw_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cnt_en) begin
                        state <= RUN;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    if (push_c) begin
                        bus.hw_wr_en  <= 1'b1;
                        bus.hw_wrdata <= cnt_nxt_c;
                        bus.ovf_o     <= ovf_nxt_c;
                        cnt           <= '0;
                        ovf           <= 1'b0;
                        if (!bus.cnt_en) begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt_nxt_c;
                        ovf <= ovf_nxt_c;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/qf_hw_evcnt.md
QF_HW_EVCNT -- requirements
Module: qf_hw_evcnt

Interface
REQ-001 Parameter PAR_BIT_WIDTH, default 10, width of event count and hw_wrdata.
REQ-002 Parameter PAR_PERIOD, default 256, RUN cycles per automatic push (legal 2..65535).
REQ-003 sys_clk  in  1  single clock; all state on its rising edge.
REQ-004 sys_rst  in  1  reset, asynchronous, active-high.
REQ-005 evt_i  in  1  event strobe, one count per high cycle.
REQ-006 cnt_en  in  1  level; counting enabled while high.
REQ-007 snap_req  in  1  one-cycle software snapshot request.
REQ-008 hw_wrdata  out  PAR_BIT_WIDTH  count snapshot; drives downstream hardware-written register data.
REQ-009 hw_wr_en  out  1  one-cycle write strobe qualifying hw_wrdata.
REQ-010 ovf_o  out  1  overflow flag for the snapshot on hw_wrdata; valid with hw_wr_en.

Function
REQ-011 FSM states SHALL be IDLE and RUN; IDLE->RUN when cnt_en=1; RUN->IDLE when cnt_en=0.
REQ-012 IDLE->RUN transition SHALL clear count, timer and overflow; an event in that cycle is not counted.
REQ-013 In RUN with cnt_en=1, count SHALL increment by 1 per cycle with evt_i=1, saturating at 2^PAR_BIT_WIDTH-1.
REQ-014 An increment attempted at saturation SHALL set a sticky overflow bit.
REQ-015 Timer SHALL count RUN cycles 0..PAR_PERIOD-1; terminal = timer at PAR_PERIOD-1.
REQ-016 Push condition in RUN: terminal, or snap_req=1 (see REQ-025), or cnt_en=0.
REQ-017 On push cycle, registered outputs SHALL load next cycle: hw_wrdata = count including this cycle's event (saturated, not counted when cnt_en=0), ovf_o = sticky overflow including this cycle, hw_wr_en = 1.
REQ-018 hw_wr_en SHALL be high exactly one cycle per push (latency 1 cycle from push condition).
REQ-019 On push, count, timer and overflow SHALL restart from 0 (state stays RUN unless cnt_en=0).
REQ-020 Coincident push causes (terminal, snap_req, cnt_en drop) SHALL produce a single push.
REQ-021 hw_wrdata and ovf_o SHALL hold their last pushed values between pushes.
REQ-022 snap_req and evt_i in IDLE SHALL be ignored; no pushes in IDLE.

Reset
REQ-023 sys_rst=1 SHALL immediately force state IDLE, count 0, timer 0, overflow 0, hw_wr_en 0, hw_wrdata 0, ovf_o 0.
REQ-024 Reset during RUN SHALL discard the partial count with no push; the first cycle after release is IDLE.

Configuration
REQ-025 Macro QF_HW_EVCNT_SNAP_REQ_EN defined: snap_req is a push cause; undefined: snap_req port present but ignored, pushes only on terminal or cnt_en drop.

Structure
REQ-026 Package qf_hw_evcnt_pkg SHALL hold the state enum (IDLE, RUN) and default constants for PAR_BIT_WIDTH and PAR_PERIOD.
REQ-027 Period timer SHALL be sub-module qf_hw_evcnt_tmr (clear, enable inputs; terminal output); count/FSM stay in top.

Verification (PAR_BIT_WIDTH=10, PAR_PERIOD=16 unless stated)
REQ-028 cnt_en=1, evt_i=1 for 16 RUN cycles -> single hw_wr_en pulse next cycle, hw_wrdata=16, ovf_o=0; next period repeats.
REQ-029 PAR_PERIOD=2048, evt_i=1 continuously -> hw_wrdata=1023, ovf_o=1; following period with 5 events -> hw_wrdata=5, ovf_o=0.
REQ-030 Macro defined, 3 events then snap_req at RUN cycle 5 -> push hw_wrdata=3 (plus event in cycle 5 if present); next auto push 16 cycles after snap.
REQ-031 7 events then cnt_en=0 -> push hw_wrdata=7, state IDLE, no further hw_wr_en while cnt_en=0.
REQ-032 sys_rst asserted mid-RUN with count 9 -> hw_wr_en, hw_wrdata, ovf_o go 0 without clock; no push after release.
REQ-033 Macro undefined, snap_req pulsed every 4 cycles -> pushes only every 16 cycles; snap_req coincident with terminal (macro defined) -> exactly one pulse.
